// File: rtl/rca_multiword_add_ctrl.sv
// rca_multiword_add_ctrl
//   Performs one (NWORDS*WIDTH)-bit unsigned addition by reusing a single WIDTH-bit ripple-carry
//   slice over NWORDS cycles, least-significant word first, with the carry registered between
//   words. Operands arrive on a valid/ready handshake; the result leaves on a second one.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept an operand set (IDLE)
//   in_a/in_b  W-bit operands, in_cin carry into word 0
//   out_valid  result available (DONE)
//   out_ready  consumer accepts the result
//   out_sum    A + B + cin modulo 2^W
//   out_cout   carry out of the most significant word
//   busy       high in RUN or DONE
module rca_multiword_add_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH*NWORDS-1:0]   in_a,
  input  logic [WIDTH*NWORDS-1:0]   in_b,
  input  logic                      in_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH*NWORDS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      busy
);

  localparam int unsigned W       = WIDTH * NWORDS;
  localparam int unsigned IdxW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [W-1:0]      op_a_q;
  logic [W-1:0]      op_b_q;

  logic [WIDTH-1:0]  slice_a;
  logic [WIDTH-1:0]  slice_b;
  logic [WIDTH-1:0]  slice_sum;
  logic [WIDTH:0]    chain;

  // Shared ripple-carry slice: operand word idx plus the registered carry.
  always_comb begin
    slice_a   = op_a_q[idx_q*WIDTH +: WIDTH];
    slice_b   = op_b_q[idx_q*WIDTH +: WIDTH];
    slice_sum = '0;
    chain     = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < WIDTH; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain[i];
      chain[i+1]   = (slice_a[i] & slice_b[i]) | (chain[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_a_q  <= in_a;
            op_b_q  <= in_b;
            carry_q <= in_cin;
            idx_q   <= '0;
            out_sum <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          out_sum[idx_q*WIDTH +: WIDTH] <= slice_sum;
          carry_q <= chain[WIDTH];
          if (idx_q == LastIdx) begin
            out_cout <= chain[WIDTH];
            state_q  <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs depend on state only, never on the request inputs.
  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun) || (state_q == StDone);

endmodule

// File: tb/tb_rca_multiword_add_ctrl.sv
module tb_rca_multiword_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [31:0] in_a, in_b, out_sum;

  // Single-word instance exercises the NWORDS=1 corner.
  logic        n1_in_valid, n1_in_ready, n1_in_cin, n1_out_valid, n1_out_ready;
  logic        n1_out_cout, n1_busy;
  logic [7:0]  n1_in_a, n1_in_b, n1_out_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_multiword_add_ctrl #(.WIDTH(8), .NWORDS(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  rca_multiword_add_ctrl #(.WIDTH(8), .NWORDS(1)) u_dut_n1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (n1_in_valid),
    .in_ready  (n1_in_ready),
    .in_a      (n1_in_a),
    .in_b      (n1_in_b),
    .in_cin    (n1_in_cin),
    .out_valid (n1_out_valid),
    .out_ready (n1_out_ready),
    .out_sum   (n1_out_sum),
    .out_cout  (n1_out_cout),
    .busy      (n1_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on the 4-word instance with latency and handshake checks.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [31:0] esum, input logic ecout);
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_cin = 1'b1;
    check({name, "_busy"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_sum"}, out_sum, esum);
    check({name, "_cout"}, out_cout, ecout);
    check({name, "_ready_in_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_popped"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] held_sum;
    logic        held_cout;
    logic [32:0] exp_q[$];
    int          acc_cyc[$];
    int          n_acc, n_pop, done_ops, pend, lat;
    logic [32:0] pend_exp;
    logic [8:0]  e1;

    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    vecs[7] = '{32'hDEADBEEF, 32'h10000000, 1'b0, 32'hEEADBEEF, 1'b0};
    vecs[8] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    n1_in_valid = 1'b0; n1_out_ready = 1'b0; n1_in_a = '0; n1_in_b = '0; n1_in_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_flags", {in_ready, out_valid, busy, out_cout}, 4'b1000);
    check("reset_sum", out_sum, 0);
    check("reset_n1_flags", {n1_in_ready, n1_out_valid, n1_busy}, 3'b100);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // Result held under back-pressure while new requests are offered
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h0000FFFF; in_b = 32'h00000001; in_cin = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hold_latency", lat, 4);
    held_sum = out_sum; held_cout = out_cout;
    check("hold_sum_value", held_sum, 32'h00010000);
    for (int c = 0; c < 5; c++) begin
      in_a = $urandom;
      @(negedge clk);
      check("hold_sum", out_sum, held_sum);
      check("hold_cout", out_cout, held_cout);
      check("hold_flags", {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    // in_valid was high on the pop edge; it must not have been taken
    check("no_bypass", {in_ready, busy, out_valid}, 3'b100);
    in_valid = 1'b0; out_ready = 1'b0;

    // Reset in the middle of RUN at idx=2
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'h00000001; in_cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("midrun_reset_sum", out_sum, 0);
    do_op("post_reset", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0);

    // Streaming with in_valid and out_ready held high
    n_acc = 0; n_pop = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() > 0) check("stream_result", {out_cout, out_sum}, exp_q.pop_front());
        else check("stream_spurious", 1, 0);
        n_pop++;
      end
      if (in_ready && n_acc < 4) begin
        in_valid = 1'b1;
        in_a = vecs[n_acc + 1].a; in_b = vecs[n_acc + 1].b; in_cin = vecs[n_acc + 1].cin;
        exp_q.push_back({vecs[n_acc + 1].cout, vecs[n_acc + 1].sum});
        acc_cyc.push_back(c);
        n_acc++;
      end else if (n_acc == 4 && in_ready) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream_pops", n_pop, 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("stream_spacing", acc_cyc[i] - acc_cyc[i-1], 6);

    // NWORDS=1 instance: one RUN cycle, result the cycle after
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n1_in_valid = 1'b1; n1_in_a = 8'($urandom); n1_in_b = 8'($urandom); n1_in_cin = 1'($urandom);
      e1 = {1'b0, n1_in_a} + {1'b0, n1_in_b} + {8'd0, n1_in_cin};
      @(negedge clk);
      n1_in_valid = 1'b0;
      check("n1_running", {n1_busy, n1_out_valid}, 2'b10);
      @(negedge clk);
      check("n1_valid", n1_out_valid, 1);
      check("n1_result", {n1_out_cout, n1_out_sum}, e1);
      n1_out_ready = 1'b1;
      @(negedge clk);
      n1_out_ready = 1'b0;
    end

    // Random traffic with a scoreboard
    done_ops = 0; pend = 0; pend_exp = '0;
    for (int c = 0; c < 20000 && done_ops < 300; c++) begin
      @(negedge clk);
      if (in_ready && out_valid) check("rnd_ready_and_valid", 1, 0);
      if (in_ready === busy) check("rnd_busy_vs_ready", busy, !in_ready);
      if (out_valid && pend == 0) check("rnd_spurious_valid", 1, 0);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        check("rnd_result", {out_cout, out_sum}, pend_exp);
        pend = 0;
        done_ops++;
      end
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
      if ($urandom_range(0, 7) == 0) in_b = ~in_a;
      if (in_valid && in_ready) begin
        if (pend != 0) check("rnd_double_accept", 1, 0);
        pend_exp = {1'b0, in_a} + {1'b0, in_b} + {32'd0, in_cin};
        pend = 1;
      end
    end
    check("rnd_ops_done", done_ops, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
